// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-issue fetch stage driving a 1-cycle synchronous instruction RAM.
// Ports:
//   clock, reset           clock and asynchronous active-high reset
//   stall                  decode stall; holds the output word and blocks new reads
//   branch_taken/_target   one-cycle PC redirect; target bits [1:0] are forced to 00
//   imem_en/imem_addr      read request to instruction memory (combinational from pc)
//   imem_data              read data, valid the cycle after the request edge
//   instr_out/pc/valid     registered instruction word handed to decode
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid
);
   typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, infl_pc_q, infl_pc_d;
   logic        infl_q, infl_d;
   logic        skid_v_q, skid_v_d;
   logic [31:0] skid_data_q, skid_data_d, skid_pc_q, skid_pc_d;
   logic [31:0] out_q, out_d, opc_q, opc_d;
   logic        ov_q, ov_d;
   assign imem_en     = (state_q != BOOT) && !stall && !branch_taken;
   assign imem_addr   = pc_q;
   assign instr_out   = out_q;
   assign instr_pc    = opc_q;
   assign instr_valid = ov_q;
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      infl_d      = 1'b0;
      infl_pc_d   = infl_pc_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      skid_pc_d   = skid_pc_q;
      out_d       = out_q;
      opc_d       = opc_q;
      ov_d        = ov_q;
      if (branch_taken) begin
         // Redirect wins over stall; leaving infl_d at 0 drops the response already in flight.
         pc_d     = branch_target & ~32'h3;
         skid_v_d = 1'b0;
         ov_d     = 1'b0;
         state_d  = FETCH;
      end else begin
         if (imem_en) begin
            pc_d      = pc_q + 32'd4;
            infl_d    = 1'b1;
            infl_pc_d = pc_q;
         end
         if (stall) begin
            // The response cannot be re-read from the RAM later, so park it.
            if (infl_q) begin
               skid_v_d    = 1'b1;
               skid_data_d = imem_data;
               skid_pc_d   = infl_pc_q;
            end
            state_d = (state_q == BOOT) ? FETCH : HOLD;
         end else begin
            state_d = FETCH;
            if (skid_v_q) begin
               out_d    = skid_data_q;
               opc_d    = skid_pc_q;
               ov_d     = 1'b1;
               skid_v_d = 1'b0;
            end else if (infl_q) begin
               out_d = imem_data;
               opc_d = infl_pc_q;
               ov_d  = 1'b1;
            end else begin
               ov_d = 1'b0;
            end
         end
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         infl_q      <= 1'b0;
         infl_pc_q   <= 32'h0;
         skid_v_q    <= 1'b0;
         skid_data_q <= 32'h0;
         skid_pc_q   <= 32'h0;
         out_q       <= 32'h0;
         opc_q       <= 32'h0;
         ov_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         infl_q      <= infl_d;
         infl_pc_q   <= infl_pc_d;
         skid_v_q    <= skid_v_d;
         skid_data_q <= skid_data_d;
         skid_pc_q   <= skid_pc_d;
         out_q       <= out_d;
         opc_q       <= opc_d;
         ov_q        <= ov_d;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench for instruction_fetch_unit with a 1-cycle RAM model.
module tb_instruction_fetch_unit;
   localparam logic [31:0] K = 32'hA5A5_0000;
   logic        clock = 1'b0;
   logic        reset, stall, branch_taken;
   logic [31:0] branch_target;
   logic        imem_en;
   logic [31:0] imem_addr, imem_data, instr_out, instr_pc;
   logic        instr_valid;
   logic        reset2;
   logic        imem_en2;
   logic [31:0] imem_addr2, imem_data2, instr_out2, instr_pc2;
   logic        instr_valid2;
   int n_cmp = 0;
   int n_err = 0;
   always #5 clock = ~clock;
   instruction_fetch_unit dut (
      .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_data(imem_data), .instr_out(instr_out), .instr_pc(instr_pc),
      .instr_valid(instr_valid)
   );
   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clock(clock), .reset(reset2), .stall(1'b0), .branch_taken(1'b0),
      .branch_target(32'h0), .imem_en(imem_en2), .imem_addr(imem_addr2),
      .imem_data(imem_data2), .instr_out(instr_out2), .instr_pc(instr_pc2),
      .instr_valid(instr_valid2)
   );
   always @(posedge clock) begin
      if (imem_en) imem_data <= imem_addr ^ K;
      if (imem_en2) imem_data2 <= imem_addr2 ^ K;
   end
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      imem_data = 32'h0;
      imem_data2 = 32'h0;
      reset = 1'b1;
      reset2 = 1'b1;
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = 32'h0;
      #3;
      chk("rst_valid", instr_valid, 0);
      chk("rst_out", instr_out, 0);
      chk("rst_pc", instr_pc, 0);
      chk("rst_en", imem_en, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst2_addr", imem_addr2, 32'hFFFF_FFF8);
      chk("rst2_pc", instr_pc2, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("e1_en", imem_en, 1);
      chk("e1_addr", imem_addr, 32'h0);
      chk("e1_valid", instr_valid, 0);
      tick();
      chk("e2_valid", instr_valid, 0);
      chk("e2_addr", imem_addr, 32'h4);
      tick();
      chk("e3_valid", instr_valid, 1);
      chk("e3_pc", instr_pc, 32'h0);
      chk("e3_out", instr_out, 32'hA5A5_0000);
      tick();
      chk("e4_pc", instr_pc, 32'h4);
      tick();
      chk("e5_pc", instr_pc, 32'h8);
      chk("e5_out", instr_out, 32'hA5A5_0008);
      stall = 1'b1;
      #1;
      chk("stall_en", imem_en, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", instr_pc, 32'h8);
         chk("stall_valid", instr_valid, 1);
         chk("stall_en_hold", imem_en, 0);
      end
      stall = 1'b0;
      #1;
      chk("unstall_addr", imem_addr, 32'h10);
      tick();
      chk("skid_pc", instr_pc, 32'hC);
      chk("skid_out", instr_out, 32'hA5A5_000C);
      tick();
      chk("post_skid_pc", instr_pc, 32'h10);
      tick();
      chk("post_skid_pc2", instr_pc, 32'h14);
      branch_taken = 1'b1;
      branch_target = 32'h0000_0103;
      #1;
      chk("br_en", imem_en, 0);
      tick();
      branch_taken = 1'b0;
      #1;
      chk("br_valid", instr_valid, 0);
      chk("br_addr", imem_addr, 32'h100);
      chk("br_en2", imem_en, 1);
      tick();
      chk("br_valid2", instr_valid, 0);
      tick();
      chk("br_tgt_pc", instr_pc, 32'h100);
      chk("br_tgt_out", instr_out, 32'hA5A5_0100);
      chk("br_tgt_valid", instr_valid, 1);
      tick();
      chk("br_next_pc", instr_pc, 32'h104);
      stall = 1'b1;
      tick();
      chk("bs_hold_pc", instr_pc, 32'h104);
      branch_taken = 1'b1;
      branch_target = 32'h0000_0200;
      tick();
      branch_taken = 1'b0;
      chk("bs_valid", instr_valid, 0);
      chk("bs_addr", imem_addr, 32'h200);
      tick();
      chk("bs_valid2", instr_valid, 0);
      chk("bs_addr2", imem_addr, 32'h200);
      stall = 1'b0;
      tick();
      chk("bs_no_skid", instr_valid, 0);
      tick();
      chk("bs_tgt_pc", instr_pc, 32'h200);
      chk("bs_tgt_valid", instr_valid, 1);
      stall = 1'b1;
      tick();
      chk("ar_hold_pc", instr_pc, 32'h200);
      #2;
      reset = 1'b1;
      stall = 1'b0;
      #1;
      chk("ar_valid", instr_valid, 0);
      chk("ar_out", instr_out, 0);
      chk("ar_pc", instr_pc, 0);
      chk("ar_en", imem_en, 0);
      chk("ar_addr", imem_addr, 32'h0);
      reset = 1'b0;
      tick();
      chk("ar_e1_addr", imem_addr, 32'h0);
      tick();
      chk("ar_e2_valid", instr_valid, 0);
      tick();
      chk("ar_e3_pc", instr_pc, 32'h0);
      chk("ar_e3_valid", instr_valid, 1);
      tick();
      chk("ar_e4_pc", instr_pc, 32'h4);
      reset2 = 1'b0;
      tick();
      chk("w_en", imem_en2, 1);
      chk("w_addr", imem_addr2, 32'hFFFF_FFF8);
      tick();
      chk("w_valid0", instr_valid2, 0);
      tick();
      chk("w_pc0", instr_pc2, 32'hFFFF_FFF8);
      chk("w_valid1", instr_valid2, 1);
      tick();
      chk("w_pc1", instr_pc2, 32'hFFFF_FFFC);
      tick();
      chk("w_pc2", instr_pc2, 32'h0000_0000);
      chk("w_out2", instr_out2, 32'hA5A5_0000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be 00.
REQ-003 Port clock  input  1  system clock; all state updates SHALL occur on its rising edge only.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Port stall  input  1  downstream pipeline stall; while high, the output word is held.
REQ-006 Port branch_taken  input  1  single-cycle PC redirect request.
REQ-007 Port branch_target  input  32  redirect address; bits [1:0] SHALL be ignored and treated as 00.
REQ-008 Port imem_en  output  1  instruction memory read enable (combinational).
REQ-009 Port imem_addr  output  32  instruction memory byte address, equal to pc (combinational).
REQ-010 Port imem_data  input  32  read data, valid the cycle after the edge at which imem_en was sampled high (1-cycle synchronous RAM).
REQ-011 Port instr_out  output  32  registered instruction word to the decode stage.
REQ-012 Port instr_pc  output  32  registered address of instr_out.
REQ-013 Port instr_valid  output  1  registered; high when instr_out holds a live instruction.

Function
REQ-014 The state machine SHALL have exactly three states: BOOT, FETCH and HOLD; BOOT moves to FETCH on the first edge after reset release.
REQ-015 imem_en SHALL be 1 only when state is FETCH or HOLD, stall=0 and branch_taken=0; imem_addr SHALL always equal pc.
REQ-016 On each edge with imem_en=1: pc <= pc+4, inflight <= 1 and inflight_pc <= pc; otherwise inflight <= 0.
REQ-017 pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 with no error indication.
REQ-018 On an edge with stall=0 and no redirect, the output registers SHALL load from the first available of: the skid entry (which it then empties), then imem_data/inflight_pc if inflight=1; if neither is available, instr_valid <= 0.
REQ-019 On an edge with stall=1 and no redirect, instr_out, instr_pc and instr_valid SHALL hold; if inflight=1, imem_data and inflight_pc SHALL be captured into the 1-entry skid buffer, and state <= HOLD.
REQ-020 On an edge with stall=0 in HOLD, state <= FETCH; skid data SHALL be presented at the outputs before any newer word, so program order is preserved.
REQ-021 The skid buffer SHALL never overflow: one in-flight read at most, and no new read is issued while stall=1.
REQ-022 branch_taken=1 SHALL have priority over stall: at that edge pc <= {branch_target[31:2],2'b00}, skid emptied, inflight response discarded, instr_valid <= 0, state <= FETCH.
REQ-023 After a redirect, the target word SHALL be requested in the next cycle if stall=0, and no pre-redirect word SHALL ever reach instr_out.
REQ-024 Latency: from a cycle with imem_en=1 and stall=0 on both edges, the word SHALL appear at instr_out after the second rising edge.
REQ-025 In steady state with stall=0, one instruction per cycle SHALL be delivered, with instr_pc incrementing by 4.

Reset
REQ-026 While reset=1, regardless of clock: pc=RESET_PC, state=BOOT, instr_out=0, instr_pc=0, instr_valid=0, skid empty, inflight=0, imem_en=0.
REQ-027 Reset asserted mid-operation SHALL abandon any in-flight read and skid content; the first fetch after release SHALL be RESET_PC.

Verification
REQ-028 Reset release, stall=0, memory word=addr^32'hA5A5_0000 -> imem_en high from cycle 1; instr_valid rises after edge 3 with instr_pc=0, then 4, 8, 12 on consecutive edges.
REQ-029 stall=1 for 3 cycles while word @8 is output and @12 is in flight -> outputs hold @8, imem_en=0; after release, outputs show @12, @16, ... with no gap or duplicate.
REQ-030 branch_taken=1 with branch_target=32'h0000_0103 while streaming -> instr_valid=0 next cycle; next valid instr_pc=32'h100; no older address appears.
REQ-031 branch_taken=1 and stall=1 together with a full skid -> skid discarded, instr_valid=0; after stall drops, first valid instr_pc=target.
REQ-032 RESET_PC=32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-033 reset pulsed asynchronously mid-stall with a full skid -> all outputs 0 immediately; the first valid instr_pc after release is RESET_PC.
